// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: M/W forwarding, load-use stall, branch/PC-write flush,
// variable-latency data-memory wait with timeout, and saturating stall/flush counters.
`timescale 1ns/1ps
module hazard_scoreboard_unit #(
  parameter int unsigned RA_W        = 4,
  parameter int unsigned ZERO_REG_EN = 0,
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic [RA_W-1:0]  WA3E,
  input  logic [RA_W-1:0]  WA3M,
  input  logic [RA_W-1:0]  WA3W,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  RA1E,
  input  logic [RA_W-1:0]  RA2E,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             ErrClr,
  input  logic             CntClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned     WC_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ldstall, pcpend, mem_pend, memwait, mem_release;

  function automatic logic reg_match(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return (a == b) && !((ZERO_REG_EN != 0) && (a == '0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] ra);
    if (RegWriteM && reg_match(ra, WA3M))      return 2'b10;
    else if (RegWriteW && reg_match(ra, WA3W)) return 2'b01;
    else                                       return 2'b00;
  endfunction

  always_comb begin
    ldstall     = MemtoRegE && (reg_match(RA1D, WA3E) || reg_match(RA2D, WA3E));
    pcpend      = PCSrcD || PCSrcE || PCSrcM;
    mem_pend    = MemReqM && !MemReadyM;
    memwait     = mem_pend && (wait_cnt_q < TIMEOUT_V);
    mem_release = mem_pend && !memwait;

    ForwardAE = fwd_sel(RA1E);
    ForwardBE = fwd_sel(RA2E);
    // A memory wait freezes the whole pipe; branch and load-use flushes are
    // deferred until the access completes or is forcibly released.
    if (memwait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end else begin
      StallF = ldstall || pcpend;
      StallD = ldstall;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = pcpend || PCSrcW || BranchTakenE;
      FlushE = ldstall || BranchTakenE;
      FlushW = 1'b0;
    end

    if (!reset) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
  end

  always_comb begin
    wait_cnt_d = memwait ? wait_cnt_q + WC_W'(1) : '0;

    mem_err_d = mem_err_q;
    if (ErrClr)           mem_err_d = 1'b0;
    else if (mem_release) mem_err_d = 1'b1;

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (CntClr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (FlushE && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemErr   = mem_err_q;
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench for hazard_scoreboard_unit: a default instance and a
// zero-register instance with a 3-bit counter for saturation.
`timescale 1ns/1ps
module tb_hazard_scoreboard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic [3:0] WA3E, WA3M, WA3W, RA1D, RA2D, RA1E, RA2E;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic       MemReqM, MemReadyM, ErrClr, CntClr;

  logic        sf_m, sd_m, se_m, sm_m, fd_m, fe_m, fw_m, err_m;
  logic [1:0]  fa_m, fb_m;
  logic [15:0] sc_m, fc_m;
  logic        sf_z, sd_z, se_z, sm_z, fd_z, fe_z, fw_z, err_z;
  logic [1:0]  fa_z, fb_z;
  logic [2:0]  sc_z, fc_z;

  hazard_scoreboard_unit #(.RA_W(4), .ZERO_REG_EN(0), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .ErrClr(ErrClr), .CntClr(CntClr),
    .StallF(sf_m), .StallD(sd_m), .StallE(se_m), .StallM(sm_m), .FlushD(fd_m), .FlushE(fe_m),
    .FlushW(fw_m), .ForwardAE(fa_m), .ForwardBE(fb_m), .MemErr(err_m), .StallCnt(sc_m), .FlushCnt(fc_m));

  hazard_scoreboard_unit #(.RA_W(4), .ZERO_REG_EN(1), .MEM_TIMEOUT(8), .CNT_W(3)) dut_z (
    .clk(clk), .reset(reset), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .ErrClr(ErrClr), .CntClr(CntClr),
    .StallF(sf_z), .StallD(sd_z), .StallE(se_z), .StallM(sm_z), .FlushD(fd_z), .FlushE(fe_z),
    .FlushW(fw_z), .ForwardAE(fa_z), .ForwardBE(fb_z), .MemErr(err_z), .StallCnt(sc_z), .FlushCnt(fc_z));

  logic [11:0] vec_m, vec_z;
  assign vec_m = {sf_m, sd_m, se_m, sm_m, fd_m, fe_m, fw_m, fa_m, fb_m, err_m};
  assign vec_z = {sf_z, sd_z, se_z, sm_z, fd_z, fe_z, fw_z, fa_z, fb_z, err_z};

  typedef struct {
    string       name;
    bit          sel;
    logic [11:0] exp;
    bit          cchk;
    logic [15:0] sc;
    logic [15:0] fc;
  } chk_t;

  chk_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event chk_ev;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,MemErr}
  function automatic logic [11:0] mk(input bit sf, sd, se, sm, fd, fe, fw,
                                     input logic [1:0] fa, fb, input bit err);
    return {sf, sd, se, sm, fd, fe, fw, fa, fb, err};
  endfunction

  logic [11:0] V0, VRST, VWAIT, VWAIT_E, VLD;

  task automatic push(input string n, input bit sel, input logic [11:0] e,
                      input bit cchk = 1'b0, input logic [15:0] sc = '0, input logic [15:0] fc = '0);
    chk_t c;
    c.name = n; c.sel = sel; c.exp = e; c.cchk = cchk; c.sc = sc; c.fc = fc;
    q.push_back(c);
  endtask

  task automatic idle();
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    WA3E = 0; WA3M = 0; WA3W = 0; RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
    MemReqM = 0; MemReadyM = 0; ErrClr = 0; CntClr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Monitor: outputs are sampled at the falling edge, or immediately on chk_ev.
  initial begin
    chk_t        c;
    logic [11:0] act;
    logic [15:0] asc, afc;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        c   = q.pop_front();
        act = c.sel ? vec_z : vec_m;
        asc = c.sel ? {13'd0, sc_z} : sc_m;
        afc = c.sel ? {13'd0, fc_z} : fc_m;
        n_tests++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: outputs got %b expected %b", c.name, act, c.exp);
        end
        if (c.cchk) begin
          n_tests++;
          if (asc !== c.sc || afc !== c.fc) begin
            n_fail++;
            $display("FAIL %s_cnt: stall/flush cnt got %0d/%0d expected %0d/%0d",
                     c.name, asc, afc, c.sc, c.fc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    V0      = mk(0,0,0,0,0,0,0,2'b00,2'b00,0);
    VRST    = mk(0,0,0,0,1,1,1,2'b00,2'b00,0);
    VWAIT   = mk(1,1,1,1,0,0,1,2'b00,2'b00,0);
    VWAIT_E = mk(1,1,1,1,0,0,1,2'b00,2'b00,1);
    VLD     = mk(1,1,0,0,0,1,0,2'b00,2'b00,0);

    reset = 1'b0;
    idle();
    step(); push("reset", 0, VRST, 1, 0, 0); push("reset_z", 1, VRST, 1, 0, 0);
    step(); reset = 1'b1; push("idle", 0, V0, 1, 0, 0);

    // Forwarding: M wins over W, W alone, register 0 behaviour
    step(); RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3;
    push("fwd_m", 0, mk(0,0,0,0,0,0,0,2'b10,2'b00,0));
    push("fwd_m_z", 1, mk(0,0,0,0,0,0,0,2'b10,2'b00,0));
    step(); RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 3;
    push("fwd_w", 0, mk(0,0,0,0,0,0,0,2'b01,2'b01,0));
    step(); RegWriteM = 1; RegWriteW = 1;
    push("fwd_r0", 0, mk(0,0,0,0,0,0,0,2'b10,2'b10,0));
    push("fwd_r0_z", 1, V0);
    step(); MemtoRegE = 1;
    push("ld_r0", 0, VLD); push("ld_r0_z", 1, V0);
    step(); CntClr = 1;
    push("cntclr", 0, V0, 1, 1, 1); push("cntclr_z", 1, V0, 1, 0, 0);

    // Load-use stall
    step(); MemtoRegE = 1; WA3E = 5; RA2D = 5;
    push("ldstall", 0, VLD, 1, 0, 0); push("ldstall_z", 1, VLD);
    step(); push("after_ld", 0, V0, 1, 1, 1); push("after_ld_z", 1, V0, 1, 1, 1);

    // Three-cycle memory wait then ready
    for (int i = 0; i < 3; i++) begin
      step(); MemReqM = 1; push("memwait", 0, VWAIT);
    end
    step(); MemReqM = 1; MemReadyM = 1; push("mem_done", 0, V0);
    step(); push("after_wait", 0, V0, 1, 4, 1);

    // Timeout: 8 stall cycles, release on the 9th, sticky error, ErrClr
    for (int i = 0; i < 8; i++) begin
      step(); MemReqM = 1; push("tmo_wait", 0, VWAIT);
    end
    step(); MemReqM = 1; push("tmo_release", 0, V0);
    step(); push("err_set", 0, mk(0,0,0,0,0,0,0,2'b00,2'b00,1), 1, 12, 1);
    push("err_set_z", 1, mk(0,0,0,0,0,0,0,2'b00,2'b00,1), 1, 7, 1);
    step(); push("err_hold", 0, mk(0,0,0,0,0,0,0,2'b00,2'b00,1));
    step(); ErrClr = 1; push("errclr_cyc", 0, mk(0,0,0,0,0,0,0,2'b00,2'b00,1));
    step(); push("err_cleared", 0, V0);

    // Branch during memory wait: flushes deferred to the release cycle
    for (int i = 0; i < 2; i++) begin
      step(); MemReqM = 1; BranchTakenE = 1; PCSrcE = 1; push("br_wait", 0, VWAIT);
    end
    step(); MemReqM = 1; MemReadyM = 1; BranchTakenE = 1; PCSrcE = 1;
    push("br_release", 0, mk(1,0,0,0,1,1,0,2'b00,2'b00,0));
    step(); push("after_br", 0, V0, 1, 15, 2); push("after_br_z", 1, V0, 1, 7, 2);

    // ErrClr coinciding with forced release keeps MemErr clear
    for (int i = 0; i < 8; i++) begin
      step(); MemReqM = 1; push("tmo2_wait", 0, VWAIT);
    end
    step(); MemReqM = 1; ErrClr = 1; push("clr_vs_set", 0, V0);
    step(); PCSrcW = 1; push("clr_wins_pcw", 0, mk(0,0,0,0,1,0,0,2'b00,2'b00,0), 1, 23, 2);

    // Build up wait_cnt=5 with MemErr set, then async reset mid-cycle
    for (int i = 0; i < 8; i++) begin
      step(); MemReqM = 1; push("tmo3_wait", 0, VWAIT);
    end
    step(); MemReqM = 1; push("tmo3_release", 0, V0);
    for (int i = 0; i < 5; i++) begin
      step(); MemReqM = 1; push("wait_err", 0, VWAIT_E);
    end
    step(); MemReqM = 1;
    push("pre_reset", 0, VWAIT_E, 1, 36, 2); push("pre_reset_z", 1, VWAIT_E, 1, 7, 2);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    push("async_reset", 0, VRST, 1, 0, 0); push("async_reset_z", 1, VRST, 1, 0, 0);
    ->chk_ev;
    #1;

    step(); reset = 1'b1; MemReqM = 1; push("post_reset_wait", 0, VWAIT, 1, 0, 0);
    step(); push("post_reset_idle", 0, V0, 1, 1, 0);

    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
